// File: rtl/vga_pkg.sv
// Shared VGA 640x480@60 timing constants, sync polarity and small decode helpers.
package vga_pkg;

  localparam int CW    = 10;
  localparam int NUM_W = 48;

  localparam int VGA_CLK_DIV  = 4;
  localparam int VGA_H_ACTIVE = 640;
  localparam int VGA_H_FP     = 16;
  localparam int VGA_H_SYNC   = 96;
  localparam int VGA_H_BP     = 48;
  localparam int VGA_V_ACTIVE = 480;
  localparam int VGA_V_FP     = 10;
  localparam int VGA_V_SYNC   = 2;
  localparam int VGA_V_BP     = 33;

  localparam int VGA_H_TOTAL = VGA_H_ACTIVE + VGA_H_FP + VGA_H_SYNC + VGA_H_BP;
  localparam int VGA_V_TOTAL = VGA_V_ACTIVE + VGA_V_FP + VGA_V_SYNC + VGA_V_BP;

  // Both syncs are active-low for this mode.
  localparam logic HSYNC_ACT = 1'b0;
  localparam logic VSYNC_ACT = 1'b0;

  function automatic logic in_range(input logic [CW-1:0] v, input int lo, input int hi);
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/vga_pix_div.sv
// Pixel strobe generator: divides clk by CLK_DIV, gives a combinational tick and a registered pix_stb.
module vga_pix_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  output logic tick,
  output logic pix_stb
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_cnt;

  assign tick = (div_cnt == DW'(CLK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt <= '0;
      pix_stb <= 1'b0;
    end else begin
      pix_stb <= tick;
      div_cnt <= tick ? '0 : div_cnt + DW'(1);
    end
  end

endmodule

// File: rtl/vga_sync.sv
// VGA raster timing (counters, sync/de decode) plus the digit word handed to screen.
// VGA_SYNC_FRAME_LATCH_EN: numbers_concat only samples numbers_in on the frame_start edge.
module vga_sync
  import vga_pkg::*;
#(
  parameter int CLK_DIV  = VGA_CLK_DIV,
  parameter int H_ACTIVE = VGA_H_ACTIVE,
  parameter int H_FP     = VGA_H_FP,
  parameter int H_SYNC   = VGA_H_SYNC,
  parameter int H_BP     = VGA_H_BP,
  parameter int V_ACTIVE = VGA_V_ACTIVE,
  parameter int V_FP     = VGA_V_FP,
  parameter int V_SYNC   = VGA_V_SYNC,
  parameter int V_BP     = VGA_V_BP
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_W-1:0] numbers_in,
  output logic [CW-1:0]    sx,
  output logic [CW-1:0]    sy,
  output logic             de,
  output logic             hsync,
  output logic             vsync,
  output logic             pix_stb,
  output logic             frame_start,
  output logic [NUM_W-1:0] numbers_concat
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO   = H_ACTIVE + H_FP;
  localparam int HS_HI   = H_ACTIVE + H_FP + H_SYNC - 1;
  localparam int VS_LO   = V_ACTIVE + V_FP;
  localparam int VS_HI   = V_ACTIVE + V_FP + V_SYNC - 1;

  logic          tick;
  logic          h_end, v_end, wrap;
  logic [CW-1:0] sx_nxt, sy_nxt;

  vga_pix_div #(.CLK_DIV(CLK_DIV)) u_div (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .pix_stb (pix_stb)
  );

  assign h_end = (sx == CW'(H_TOTAL - 1));
  assign v_end = (sy == CW'(V_TOTAL - 1));
  assign wrap  = tick && h_end && v_end;

  always_comb begin
    sx_nxt = sx;
    sy_nxt = sy;
    if (tick) begin
      if (h_end) begin
        sx_nxt = '0;
        sy_nxt = v_end ? '0 : sy + CW'(1);
      end else begin
        sx_nxt = sx + CW'(1);
      end
    end
  end

  // Decode from the next-state counters so sync/de line up with the coordinates they ship with.
  always_ff @(posedge clk) begin
    if (rst) begin
      sx          <= '0;
      sy          <= '0;
      de          <= 1'b1;
      hsync       <= ~HSYNC_ACT;
      vsync       <= ~VSYNC_ACT;
      frame_start <= 1'b0;
    end else begin
      sx          <= sx_nxt;
      sy          <= sy_nxt;
      de          <= (sx_nxt < CW'(H_ACTIVE)) && (sy_nxt < CW'(V_ACTIVE));
      hsync       <= in_range(sx_nxt, HS_LO, HS_HI) ? HSYNC_ACT : ~HSYNC_ACT;
      vsync       <= in_range(sy_nxt, VS_LO, VS_HI) ? VSYNC_ACT : ~VSYNC_ACT;
      frame_start <= wrap;
    end
  end

`ifdef VGA_SYNC_FRAME_LATCH_EN
  // Sampling only at the frame boundary keeps the digits tear-free across a frame.
  always_ff @(posedge clk) begin
    if (rst)       numbers_concat <= '0;
    else if (wrap) numbers_concat <= numbers_in;
  end
`else
  always_ff @(posedge clk) begin
    if (rst) numbers_concat <= '0;
    else     numbers_concat <= numbers_in;
  end
`endif

endmodule
